// File: rtl/riscv_pkg.sv
// Shared front-end definitions: next-PC select codes, fetch FSM states and the NOP encoding.
package riscv_pkg;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_FAULT
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory channel: valid/ready request, valid-only response.
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] addr;
    logic            rsp_valid;
    logic [31:0]     rsp_data;

    modport master (
        output req_valid, addr,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, addr,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC select and alignment check, shared with any future pipelined front end.
module next_pc_calc
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [1:0]      i_pc_src,
    input  logic [XLEN-1:0] i_pc_target,
    input  logic [XLEN-1:0] i_jalr_target,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_misaligned
);

    always_comb begin
        o_next_pc = i_pc + XLEN'(4);
        case (i_pc_src)
            PCSRC_PLUS4:  o_next_pc = i_pc + XLEN'(4);
            PCSRC_TARGET: o_next_pc = i_pc_target;
            // JALR drops bit 0, so only bit 1 can still make it misaligned.
            PCSRC_JALR:   o_next_pc = i_jalr_target & ~XLEN'(1);
            default:      o_next_pc = i_pc + XLEN'(4);
        endcase
    end

    assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Owns the PC, fetches one instruction at a time from imem and holds it for decode until retire.
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            retire,
    pc_fetch_unit_if.master imem,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_fault
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic            r_running;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            w_load_instr;
    logic            w_take_retire;
    logic [XLEN-1:0] w_next_pc;
    logic            w_misaligned;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc (
        .i_pc          (r_pc),
        .i_pc_src      (pc_src),
        .i_pc_target   (pc_target),
        .i_jalr_target (jalr_target),
        .o_next_pc     (w_next_pc),
        .o_misaligned  (w_misaligned)
    );

    // r_running keeps req_valid low while reset is held and until the first edge after release.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_REQ;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_running <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        imem.req_valid = 1'b0;
        w_load_instr   = 1'b0;
        w_take_retire  = 1'b0;
        case (r_state)
            ST_REQ: begin
                imem.req_valid = r_running;
                if (r_running && imem.req_ready) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem.rsp_valid) begin
                    w_load_instr = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (retire) begin
                    w_take_retire = 1'b1;
                    w_state_next  = w_misaligned ? ST_FAULT : ST_REQ;
                end
            end
            ST_FAULT: w_state_next = ST_FAULT;
            default:  w_state_next = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_VECTOR;
            r_instr <= NOP_INSTR;
        end else begin
            if (w_load_instr) r_instr <= imem.rsp_data;
            // A faulting target leaves the PC on the instruction that produced it.
            if (w_take_retire && !w_misaligned) r_pc <= w_next_pc;
        end
    end

    assign imem.addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == ST_HOLD);
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + XLEN'(4);
    assign fetch_fault = (r_state == ST_FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a hand-driven imem and hand-computed expected PCs/words.
module tb_pc_fetch_unit;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic [31:0] pc_target;
    logic [31:0] jalr_target;
    logic        retire;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fault;

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_unit_if #(.XLEN(XLEN)) imem ();

    pc_fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .jalr_target (jalr_target),
        .retire      (retire),
        .imem        (imem),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // Answers one fetch: waits (bounded) for the request, accepts it, returns data next cycle.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data);
        int cyc = 0;
        imem.req_ready = 1'b1;
        while (imem.req_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (imem.req_valid !== 1'b1 || imem.addr !== exp_addr) begin
            n_bad++;
            $display("FAIL serve_req: valid=%b addr=%h, want valid=1 addr=%h", imem.req_valid, imem.addr, exp_addr);
        end
        @(negedge clk);
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = data;
        @(negedge clk);
        imem.rsp_valid = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== data || pc !== exp_addr) begin
            n_bad++;
            $display("FAIL serve_rsp: valid=%b instr=%h pc=%h, want 1 %h %h", instr_valid, instr, pc, data, exp_addr);
        end
    endtask

    task automatic do_retire(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] jt);
        pc_src      = src;
        pc_target   = tgt;
        jalr_target = jt;
        retire      = 1'b1;
        @(negedge clk);
        retire = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; retire = 1'b0; pc_src = 2'b00; pc_target = '0; jalr_target = '0;
        imem.req_ready = 1'b0; imem.rsp_valid = 1'b0; imem.rsp_data = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (imem.req_valid !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: req=%b iv=%b fault=%b, want 0 0 0", imem.req_valid, instr_valid, fetch_fault);
        end
        n_cmp++;
        if (pc !== 32'h0 || instr !== 32'h0000_0013) begin
            n_bad++;
            $display("FAIL reset_regs: pc=%h instr=%h, want 00000000 00000013", pc, instr);
        end
        imem.req_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (imem.req_valid !== 1'b1 || imem.addr !== 32'h0) begin
            n_bad++;
            $display("FAIL first_req: valid=%b addr=%h, want 1 00000000", imem.req_valid, imem.addr);
        end
        @(negedge clk);
        n_cmp++;
        if (imem.req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL first_wait: req=%b iv=%b, want 0 0", imem.req_valid, instr_valid);
        end
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = 32'h0050_0093;
        @(negedge clk);
        imem.rsp_valid = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || pc !== 32'h0 || pc_plus4 !== 32'h4) begin
            n_bad++;
            $display("FAIL first_hold: iv=%b instr=%h pc=%h pc4=%h, want 1 00500093 00000000 00000004", instr_valid, instr, pc, pc_plus4);
        end
    endtask

    task automatic test_sequential;
        do_retire(2'b00, 32'h0, 32'h0);
        n_cmp++;
        if (instr_valid !== 1'b0 || pc !== 32'h4) begin
            n_bad++;
            $display("FAIL seq_plus4: iv=%b pc=%h, want 0 00000004", instr_valid, pc);
        end
        serve(32'h4, 32'h00a0_0113);
        do_retire(2'b01, 32'h40, 32'h0);
        serve(32'h40, 32'h0000_006f);
        n_cmp++;
        if (pc_plus4 !== 32'h44) begin
            n_bad++;
            $display("FAIL seq_link: pc_plus4=%h, want 00000044", pc_plus4);
        end
        do_retire(2'b11, 32'h900, 32'h900);
        n_cmp++;
        if (pc !== 32'h44) begin
            n_bad++;
            $display("FAIL reserved_src: pc=%h, want 00000044", pc);
        end
        serve(32'h44, 32'h0000_0013);
    endtask

    task automatic test_jalr;
        do_retire(2'b10, 32'h0, 32'h101);
        n_cmp++;
        if (pc !== 32'h100 || fetch_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL jalr: pc=%h fault=%b, want 00000100 0", pc, fetch_fault);
        end
        serve(32'h100, 32'h0000_8067);
    endtask

    task automatic test_stall_and_stray;
        do_retire(2'b00, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            imem.rsp_valid = 1'b1;
            imem.rsp_data  = 32'hDEAD_BEEF;
            retire = 1'b1; pc_src = 2'b01; pc_target = 32'h80;
            @(negedge clk);
            n_cmp++;
            if (imem.req_valid !== 1'b1 || imem.addr !== 32'h104 || pc !== 32'h104 || instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_%0d: req=%b addr=%h pc=%h iv=%b, want 1 00000104 00000104 0", i, imem.req_valid, imem.addr, pc, instr_valid);
            end
        end
        imem.rsp_valid = 1'b0;
        retire = 1'b0;
        serve(32'h104, 32'h1234_5678);
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = 32'h0000_0BAD;
        @(negedge clk);
        imem.rsp_valid = 1'b0;
        n_cmp++;
        if (instr !== 32'h1234_5678 || instr_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stray_hold: instr=%h iv=%b, want 12345678 1", instr, instr_valid);
        end
    endtask

    task automatic test_wrap;
        do_retire(2'b10, 32'h0, 32'hFFFF_FFFD);
        n_cmp++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || fetch_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_top: pc=%h pc4=%h fault=%b, want fffffffc 00000000 0", pc, pc_plus4, fetch_fault);
        end
        serve(32'hFFFF_FFFC, 32'h0000_0013);
        do_retire(2'b00, 32'h0, 32'h0);
        n_cmp++;
        if (pc !== 32'h0 || fetch_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_zero: pc=%h fault=%b, want 00000000 0", pc, fetch_fault);
        end
        serve(32'h0, 32'h0050_0093);
    endtask

    task automatic test_fault;
        logic seen_req = 1'b0;
        do_retire(2'b01, 32'h42, 32'h0);
        n_cmp++;
        if (fetch_fault !== 1'b1 || pc !== 32'h0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_enter: fault=%b pc=%h iv=%b, want 1 00000000 0", fetch_fault, pc, instr_valid);
        end
        imem.req_ready = 1'b1;
        pc_src = 2'b00;
        retire = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (imem.req_valid !== 1'b0) seen_req = 1'b1;
        end
        retire = 1'b0;
        imem.req_ready = 1'b0;
        n_cmp++;
        if (seen_req !== 1'b0 || fetch_fault !== 1'b1 || pc !== 32'h0) begin
            n_bad++;
            $display("FAIL fault_sticky: req_seen=%b fault=%b pc=%h, want 0 1 00000000", seen_req, fetch_fault, pc);
        end
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fetch_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_clear: fault=%b, want 0", fetch_fault);
        end
        imem.req_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (imem.req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_wait: req=%b iv=%b, want 0 0", imem.req_valid, instr_valid);
        end
        imem.req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = 32'hCAFE_0001;
        @(negedge clk);
        imem.rsp_valid = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || instr !== 32'h0000_0013 || imem.req_valid !== 1'b1 || imem.addr !== 32'h0) begin
            n_bad++;
            $display("FAIL late_rsp: iv=%b instr=%h req=%b addr=%h, want 0 00000013 1 00000000", instr_valid, instr, imem.req_valid, imem.addr);
        end
        serve(32'h0, 32'h0010_0073);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jalr();
        test_stall_and_stray();
        test_wrap();
        test_fault();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
